// File: rtl/triangle_assembler.sv
// triangle_assembler
//
// Purpose:
//   Sits between the command decoder and the rasterizer. It holds a 4-slot
//   vertex register file that the decoder writes one byte at a time. On each
//   triangle command it snapshots three vertices into a FIFO. Block markers
//   are queued alongside triangles. The head entry is presented whole over a
//   valid/ready interface, in first-word-fall-through fashion.
//
// Ports:
//   clk                   in   1   clock, all logic on posedge
//   rst                   in   1   synchronous active-high reset
//   v_sel                 in   2   vertex slot for byte writes
//   v_data                in   8   vertex byte
//   v_addr                in   3   byte index 0..4 (4 = X byte, 0 = GB byte)
//   v_we                  in   1   vertex byte write strobe
//   command               in   8   0x00 = triangle, bit7 set = block marker
//   va_sel/vb_sel/vc_sel  in   2   vertex slots for triangle corners A/B/C
//   write                 in   1   push strobe
//   vertices_almost_full  out  1   back-pressure to the decoder
//   out_valid             out  1   entry available at head
//   out_ready             in   1   consumer accepts head entry
//   out_command           out  8   head command byte
//   out_va/out_vb/out_vc  out  38  {X6,Y6,Z10,R5,G6,B5} per corner
//   overflow              out  1   sticky, a push was lost while full
module triangle_assembler #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  v_sel,
  input  logic [7:0]  v_data,
  input  logic [2:0]  v_addr,
  input  logic        v_we,
  input  logic [7:0]  command,
  input  logic [1:0]  va_sel,
  input  logic [1:0]  vb_sel,
  input  logic [1:0]  vc_sel,
  input  logic        write,
  output logic        vertices_almost_full,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_command,
  output logic [37:0] out_va,
  output logic [37:0] out_vb,
  output logic [37:0] out_vc,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 8 + 3 * 38;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

  // Each vertex slot is nominally 40 bits. The top two bits of the X byte
  // never reach the unpacked vertex, so only the 38 meaningful bits are kept.
  // Unpacking then reduces to the identity on what is stored.
  logic [37:0]   rf [4];
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;

  logic          is_tri;
  logic          is_blk;
  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;

  assign is_tri   = write && (command == 8'h00);
  assign is_blk   = write && command[7];
  assign push_req = (is_tri || is_blk) && !rst;
  assign pop      = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((count < FULL_CNT) || pop);

  // The snapshot reads the register file before this cycle's byte write lands.
  always_comb begin
    push_entry = {command, {(3 * 38){1'b0}}};
    if (is_tri) begin
      push_entry = {8'h00, rf[va_sel], rf[vb_sel], rf[vc_sel]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else if (v_we) begin
      case (v_addr)
        3'd4:    rf[v_sel][37:32] <= v_data[5:0];
        3'd3:    rf[v_sel][31:24] <= v_data;
        3'd2:    rf[v_sel][23:16] <= v_data;
        3'd1:    rf[v_sel][15:8]  <= v_data;
        3'd0:    rf[v_sel][7:0]   <= v_data;
        default: ;
      endcase
    end
  end

  // The storage array needs no reset, because the pointers and count decide
  // which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Flags are decoded only from registered state, so the decoder sees no
  // combinational path from its own strobes.
  assign head                 = mem[rd_ptr];
  assign out_valid            = (count != '0);
  assign vertices_almost_full = (count >= AF_CNT);
  assign overflow             = overflow_q;
  assign out_command          = head[EW-1 -: 8];
  assign out_va               = head[113:76];
  assign out_vb               = head[75:38];
  assign out_vc               = head[37:0];

endmodule

// File: tb/tb_triangle_assembler.sv
// tb_triangle_assembler
//
// Purpose:
//   Self-checking bench for triangle_assembler. A queue-based reference model
//   tracks the FIFO contents, the register file and the overflow flag. Every
//   cycle after reset, one compare process checks the DUT outputs against
//   that model. Directed scenarios add literal expectations at key points.
//
// Ports: none (top-level bench).
module tb_triangle_assembler;

  logic        clk;
  logic        rst;
  logic [1:0]  v_sel;
  logic [7:0]  v_data;
  logic [2:0]  v_addr;
  logic        v_we;
  logic [7:0]  command;
  logic [1:0]  va_sel;
  logic [1:0]  vb_sel;
  logic [1:0]  vc_sel;
  logic        write;
  logic        vertices_almost_full;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_command;
  logic [37:0] out_va;
  logic [37:0] out_vb;
  logic [37:0] out_vc;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  triangle_assembler #(.DEPTH(8), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .v_sel(v_sel), .v_data(v_data), .v_addr(v_addr),
    .v_we(v_we), .command(command), .va_sel(va_sel), .vb_sel(vb_sel),
    .vc_sel(vc_sel), .write(write),
    .vertices_almost_full(vertices_almost_full), .out_valid(out_valid),
    .out_ready(out_ready), .out_command(out_command), .out_va(out_va),
    .out_vb(out_vb), .out_vc(out_vc), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Entries hold {command, A, B, C}. Each vertex is the
  // 40-bit slot truncated to its low 38 bits.
  logic [121:0] model_q[$];
  logic [39:0]  model_rf [4];
  logic         model_ovf;

  always @(posedge clk) begin
    logic         m_pop;
    logic         m_push;
    logic [121:0] m_entry;
    if (rst) begin
      model_q.delete();
      for (int i = 0; i < 4; i++) model_rf[i] = '0;
      model_ovf = 1'b0;
    end else begin
      m_pop  = out_ready && (model_q.size() != 0);
      m_push = write && (command == 8'h00 || command[7]);
      if (command == 8'h00)
        m_entry = {8'h00, model_rf[va_sel][37:0], model_rf[vb_sel][37:0], model_rf[vc_sel][37:0]};
      else
        m_entry = {command, 114'd0};
      if (m_push && !(model_q.size() < 8 || m_pop)) begin
        model_ovf = 1'b1;
        m_push    = 1'b0;
      end
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(m_entry);
      if (v_we && v_addr <= 3'd4) model_rf[v_sel][8*v_addr +: 8] = v_data;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("out_valid", out_valid, model_q.size() != 0);
      checkOutput("almost_full", vertices_almost_full, model_q.size() >= 6);
      checkOutput("overflow", overflow, model_ovf);
      if (model_q.size() != 0) begin
        checkOutput("out_command", out_command, model_q[0][121:114]);
        checkOutput("out_va", out_va, model_q[0][113:76]);
        checkOutput("out_vb", out_vb, model_q[0][75:38]);
        checkOutput("out_vc", out_vc, model_q[0][37:0]);
      end
    end
  end

  // Drives one cycle of inputs and then waits for the next falling edge.
  task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [2:0] addr,
                               input logic [7:0] data, input logic wr, input logic [7:0] cmd,
                               input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                               input logic rdy);
    v_we = we; v_sel = sel; v_addr = addr; v_data = data;
    write = wr; command = cmd; va_sel = a; vb_sel = b; vc_sel = c;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [1:0] sel, input logic [2:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, sel, addr, data, 1'b0, 8'h00, 2'd0, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic write_slot(input logic [1:0] sel, input logic [39:0] raw);
    for (int i = 4; i >= 0; i--) write_byte(sel, 3'(i), raw[8*i +: 8]);
  endtask

  task automatic push_cmd(input logic [7:0] cmd, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] c, input logic rdy);
    applyStimulus(1'b0, 2'd0, 3'd0, 8'h00, 1'b1, cmd, a, b, c, rdy);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0, 2'd0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    v_we = 0; v_sel = 0; v_addr = 0; v_data = 0;
    write = 0; command = 0; va_sel = 0; vb_sel = 0; vc_sel = 0; out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset almost_full", vertices_almost_full, 1'b0);
    checkOutput("reset overflow", overflow, 1'b0);

    // All-ones vertex in slot 1, which appears at the head one cycle later.
    write_slot(2'd1, 40'h3F_FFFF_FFFF);
    push_cmd(8'h00, 2'd1, 2'd1, 2'd1, 1'b0);
    checkOutput("tri1 valid", out_valid, 1'b1);
    checkOutput("tri1 va", out_va, 38'h3F_FFFF_FFFF);
    checkOutput("tri1 cmd", out_command, 8'h00);
    idle(1'b1);
    checkOutput("tri1 popped", out_valid, 1'b0);

    // The snapshot is isolated from later vertex writes.
    write_slot(2'd0, 40'h12_3456_789A);
    write_slot(2'd2, 40'h2A_BCDE_F011);
    push_cmd(8'h00, 2'd0, 2'd1, 2'd2, 1'b0);
    write_byte(2'd0, 3'd4, 8'h01);
    checkOutput("snap va", out_va, 38'h12_3456_789A);
    checkOutput("snap vc", out_vc, 38'h2A_BCDE_F011);
    // A byte write and a triangle push in the same cycle: the push sees the old slot 0.
    applyStimulus(1'b1, 2'd0, 3'd4, 8'h3F, 1'b1, 8'h00, 2'd0, 2'd0, 2'd0, 1'b0);
    write_byte(2'd0, 3'd5, 8'hFF);
    idle(1'b1);
    checkOutput("same-cycle va", out_va, 38'h01_3456_789A);
    idle(1'b1);

    // Block marker, followed by an undefined command that must be dropped.
    push_cmd(8'hB5, 2'd0, 2'd0, 2'd0, 1'b0);
    checkOutput("block cmd", out_command, 8'hB5);
    checkOutput("block va", out_va, 38'd0);
    push_cmd(8'h05, 2'd0, 2'd0, 2'd0, 1'b1);
    checkOutput("undefined dropped", out_valid, 1'b0);
    checkOutput("undefined no ovf", overflow, 1'b0);

    // Fill the FIFO and check the almost-full threshold.
    for (int i = 0; i < 8; i++) begin
      push_cmd(8'h80 + 8'(i), 2'd0, 2'd0, 2'd0, 1'b0);
      if (i == 4) checkOutput("af at 5", vertices_almost_full, 1'b0);
      if (i == 5) checkOutput("af at 6", vertices_almost_full, 1'b1);
    end
    push_cmd(8'h88, 2'd0, 2'd0, 2'd0, 1'b1);
    checkOutput("full push+pop head", out_command, 8'h81);
    checkOutput("full push+pop ovf", overflow, 1'b0);
    checkOutput("full push+pop af", vertices_almost_full, 1'b1);
    push_cmd(8'h89, 2'd0, 2'd0, 2'd0, 1'b0);
    checkOutput("push when full ovf", overflow, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    checkOutput("drained valid", out_valid, 1'b0);
    checkOutput("drained af", vertices_almost_full, 1'b0);
    checkOutput("ovf sticky", overflow, 1'b1);

    // Reset mid-stream, with a push in the reset cycle.
    for (int i = 0; i < 3; i++) push_cmd(8'hC1 + 8'(i), 2'd0, 2'd0, 2'd0, 1'b0);
    rst = 1'b1;
    push_cmd(8'hC4, 2'd0, 2'd0, 2'd0, 1'b0);
    rst = 1'b0;
    checkOutput("rst valid", out_valid, 1'b0);
    checkOutput("rst af", vertices_almost_full, 1'b0);
    checkOutput("rst ovf", overflow, 1'b0);
    push_cmd(8'hD0, 2'd0, 2'd0, 2'd0, 1'b0);
    checkOutput("post-rst valid", out_valid, 1'b1);
    checkOutput("post-rst cmd", out_command, 8'hD0);
    idle(1'b1);
    idle(1'b0);

    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
